// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;
  localparam logic [REG_AW-1:0] R_ZERO = REG_AW'(0);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_BUBBLE = 2'b01,
    HZ_HOLD   = 2'b10
  } hz_state_e;

  // Destination info of one in-flight producer.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic [1:0]        memto_reg;
  } slot_t;

  // The zero register is never a forwarding source.
  function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.dst == r) && (r != R_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-source match and priority logic: nearest producer (s1) wins over s2.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  slot_t             s1,
  input  slot_t             s2,
  output logic [1:0]        fwd_c,
  output logic              s1_hit_c
);

  always_comb begin
    fwd_c    = FWD_RF;
    s1_hit_c = use_src && slot_match(s1, src);
    if (s1_hit_c) begin
      fwd_c = FWD_EX;
    end else if (use_src && slot_match(s2, src)) begin
      fwd_c = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding select, load-use stall, flush bubble and freeze control for the 5-stage pipeline.
// Optional perf counters (stall_cnt, freeze_cnt) are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic [1:0]        id_memto_reg,
  input  logic              flush,
  input  logic              mem_busy,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [1:0]        hz_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
`endif
);

  slot_t     s1_q, s1_d, s2_q, s2_d;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_next, fwd_b_next;
  logic      hit_rs_s1, hit_rt_s1;
  logic      lu;
  hz_state_e state_q, state_d;

  hazard_fwd_sel u_sel_rs (
    .use_src  (id_use_rs),
    .src      (id_rs),
    .s1       (s1_q),
    .s2       (s2_q),
    .fwd_c    (fwd_a_next),
    .s1_hit_c (hit_rs_s1)
  );

  hazard_fwd_sel u_sel_rt (
    .use_src  (id_use_rt),
    .src      (id_rt),
    .s1       (s1_q),
    .s2       (s2_q),
    .fwd_c    (fwd_b_next),
    .s1_hit_c (hit_rt_s1)
  );

  // Load data and PC_next are not on the EX result bus one cycle ahead.
  assign lu = id_valid && !flush && (s1_q.memto_reg != WB_ALU) && (hit_rs_s1 || hit_rt_s1);

  assign pc_write    = !(lu || mem_busy);
  assign ifid_write  = !(lu || mem_busy);
  assign idex_bubble = (lu || flush) && !mem_busy;
  assign hz_state    = state_q;

  always_comb begin
    s1_d    = s1_q;
    s2_d    = s2_q;
    fwd_a_d = ForwardA;
    fwd_b_d = ForwardB;
    state_d = state_q;
    if (mem_busy) begin
      state_d = HZ_HOLD;
    end else if (flush || lu) begin
      s2_d    = s1_q;
      s1_d    = '0;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      state_d = flush ? HZ_RUN : HZ_BUBBLE;
    end else begin
      s2_d    = s1_q;
      s1_d    = '{valid: id_valid, dst: id_dst, reg_write: id_reg_write, memto_reg: id_memto_reg};
      fwd_a_d = fwd_a_next;
      fwd_b_d = fwd_b_next;
      state_d = HZ_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      ForwardA <= FWD_RF;
      ForwardB <= FWD_RF;
      state_q  <= HZ_RUN;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      ForwardA <= fwd_a_d;
      ForwardB <= fwd_b_d;
      state_q  <= state_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (!mem_busy && lu && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (mem_busy && (freeze_cnt != '1)) begin
        freeze_cnt <= freeze_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus pushes expectations, a monitor pops and checks.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_reg_write;
  logic [1:0] id_memto_reg;
  logic       flush, mem_busy;
  logic [1:0] ForwardA, ForwardB, hz_state;
  logic       pc_write, ifid_write, idex_bubble;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, freeze_cnt;
`endif

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_memto_reg (id_memto_reg),
    .flush        (flush),
    .mem_busy     (mem_busy),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .hz_state     (hz_state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .freeze_cnt   (freeze_cnt)
`endif
  );

  typedef struct {
    string       name;
    bit          chk_comb;
    logic        pcw;
    logic        bub;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_freeze = 0;

  localparam logic [1:0] ALU = 2'b00, LD = 2'b01, LNK = 2'b10;
  localparam logic [1:0] RUN = 2'b00, BUB = 2'b01, HLD = 2'b10;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: comb outputs mid-cycle, registered outputs just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_comb) begin
          check({e.name, ".pc_write"},    32'(pc_write),    32'(e.pcw));
          check({e.name, ".ifid_write"},  32'(ifid_write),  32'(e.pcw));
          check({e.name, ".idex_bubble"}, 32'(idex_bubble), 32'(e.bub));
        end
        @(posedge clk);
        #2;
        check({e.name, ".ForwardA"}, 32'(ForwardA), 32'(e.fa));
        check({e.name, ".ForwardB"}, 32'(ForwardB), 32'(e.fb));
        check({e.name, ".hz_state"}, 32'(hz_state), 32'(e.st));
`ifdef HAZ_PERF_CNT_EN
        check({e.name, ".stall_cnt"},  stall_cnt,  e.sc);
        check({e.name, ".freeze_cnt"}, freeze_cnt, e.fc);
`endif
      end
    end
  end

  // Drive one ID cycle and queue its expected response.
  task automatic step(input string name, input logic rst, input logic v,
                      input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] dst, input logic rw, input logic [1:0] mtr,
                      input logic fl, input logic bz,
                      input logic e_pcw, input logic e_bub,
                      input logic [1:0] e_fa, input logic [1:0] e_fb, input logic [1:0] e_st,
                      input bit cc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_dst = dst; id_reg_write = rw; id_memto_reg = mtr; flush = fl; mem_busy = bz;
    if (!rst) begin
      m_stall = 0;
      m_freeze = 0;
    end else begin
      if (e_st == BUB && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (e_st == HLD && m_freeze != 32'hFFFF_FFFF) m_freeze++;
    end
    e.name = name; e.chk_comb = cc; e.pcw = e_pcw; e.bub = e_bub;
    e.fa = e_fa; e.fb = e_fb; e.st = e_st; e.sc = m_stall; e.fc = m_freeze;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_dst = '0; id_reg_write = 1'b0; id_memto_reg = ALU; flush = 1'b0; mem_busy = 1'b0;

    //    name         rst v  rs urs rt urt dst rw mtr  fl bz  pcw bub fa     fb     st  cc
    step("reset0",     0, 0, 0, 0, 0, 0,  0, 0, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 0);
    step("reset1",     0, 0, 0, 0, 0, 0,  0, 0, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("add3",       1, 1, 1, 1, 2, 1,  3, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("sub_rs3",    1, 1, 3, 1, 4, 1,  5, 1, ALU, 0, 0, 1, 0, 2'b01, 2'b00, RUN, 1);
    step("add6",       1, 1, 1, 1, 2, 1,  6, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("nop",        1, 0, 0, 0, 0, 0,  0, 0, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("or_rt6",     1, 1, 1, 1, 6, 1,  7, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b10, RUN, 1);
    step("lw4",        1, 1, 1, 1, 0, 0,  4, 1, LD,  0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("add_lu4",    1, 1, 4, 1, 2, 1,  8, 1, ALU, 0, 0, 0, 1, 2'b00, 2'b00, BUB, 1);
    step("add_after4", 1, 1, 4, 1, 2, 1,  8, 1, ALU, 0, 0, 1, 0, 2'b10, 2'b00, RUN, 1);
    step("jal31",      1, 1, 0, 0, 0, 0, 31, 1, LNK, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("rd31_lu",    1, 1,31, 1, 0, 1,  9, 1, ALU, 0, 0, 0, 1, 2'b00, 2'b00, BUB, 1);
    step("rd31_fwd",   1, 1,31, 1, 0, 1,  9, 1, ALU, 0, 0, 1, 0, 2'b10, 2'b00, RUN, 1);
    step("wr0",        1, 1, 1, 1, 0, 0,  0, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("rd0",        1, 1, 0, 1, 0, 1, 10, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("lw0",        1, 1, 1, 1, 0, 0,  0, 1, LD,  0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("rd0_rt10",   1, 1, 0, 1,10, 1, 11, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b10, RUN, 1);
    step("lw12",       1, 1, 1, 1, 0, 0, 12, 1, LD,  0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("flush_lu",   1, 1,12, 1,11, 1, 13, 1, ALU, 1, 0, 1, 1, 2'b00, 2'b00, RUN, 1);
    step("or_rs12",    1, 1,12, 1, 2, 1, 13, 1, ALU, 0, 0, 1, 0, 2'b10, 2'b00, RUN, 1);
    step("busy1",      1, 1,13, 1, 0, 0, 14, 1, ALU, 0, 1, 0, 0, 2'b10, 2'b00, HLD, 1);
    step("busy2_fl",   1, 1,13, 1, 0, 0, 14, 1, ALU, 1, 1, 0, 0, 2'b10, 2'b00, HLD, 1);
    step("busy3",      1, 1,13, 1, 0, 0, 14, 1, ALU, 0, 1, 0, 0, 2'b10, 2'b00, HLD, 1);
    step("unfreeze",   1, 1,13, 1, 0, 0, 14, 1, ALU, 0, 0, 1, 0, 2'b01, 2'b00, RUN, 1);
    step("lw15",       1, 1, 1, 1, 0, 0, 15, 1, LD,  0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("lw16_lu",    1, 1,15, 1, 0, 0, 16, 1, LD,  0, 0, 0, 1, 2'b00, 2'b00, BUB, 1);
    step("lw16_go",    1, 1,15, 1, 0, 0, 16, 1, LD,  0, 0, 1, 0, 2'b10, 2'b00, RUN, 1);
    step("add16_lu",   1, 1,16, 1,16, 1, 17, 1, ALU, 0, 0, 0, 1, 2'b00, 2'b00, BUB, 1);
    step("add16_go",   1, 1,16, 1,16, 1, 17, 1, ALU, 0, 0, 1, 0, 2'b10, 2'b10, RUN, 1);
    step("lw18",       1, 1, 1, 1, 0, 0, 18, 1, LD,  0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("add18_lu",   1, 1,18, 1, 2, 1, 19, 1, ALU, 0, 0, 0, 1, 2'b00, 2'b00, BUB, 1);
    step("rst_in_bub", 0, 1,18, 1, 2, 1, 19, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);
    step("after_rst",  1, 1,18, 1, 2, 1, 19, 1, ALU, 0, 0, 1, 0, 2'b00, 2'b00, RUN, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
